fft_frame_sequencer: RTL and testbench
======================================

# fft_frame_sequencer

Host-side driver for the FFT core. It accepts a stream of real audio samples, writes one N=2^M point frame into the core through its load port, and pulses start. It waits for done, then reads back bins 0..N/2 through the same address port and emits an approximate magnitude per bin on a valid/ready stream. Frames are processed back to back: load, compute, read out, repeat.

## Interface
- width, 16, bits per real/imag component (sample and FFT word halves)
- M, 9, log2 of FFT length N (N = 512)
- RD_LAT, 1, clk_slow cycles from fft_adr change to valid fft_wd during readout (1..3)

- clk_slow  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-low (asserted when 0)
- s_valid  in  1  input sample valid
- s_ready  out  1  block accepts sample
- s_data  in  width  signed real sample
- fft_load  out  1  one-cycle write strobe to FFT load port
- fft_adr  out  M  FFT sample index (load address or readout address)
- fft_rd  out  2*width  FFT write data {real, imag}
- fft_start  out  1  one-cycle start pulse
- fft_done  in  1  FFT complete (level)
- fft_wd  in  2*width  FFT result {real, imag}, signed halves
- m_valid  out  1  magnitude output valid
- m_ready  in  1  downstream accepts magnitude
- m_index  out  M  bin index of m_mag
- m_mag  out  width+1  unsigned approximate magnitude
- m_last  out  1  high with bin N/2
- busy  out  1  high outside LOAD state

## Operation
- States: LOAD, FLUSH, KICK, WAIT, RDADR, RDWAIT, OUT.
- LOAD: s_ready=1 (decoded from state). Each s_valid&s_ready beat: next cycle fft_load=1, fft_adr=sample count, fft_rd={s_data, width'b0}. Count increments. The beat with count N-1 moves to FLUSH. Without a beat, fft_load=0, and fft_adr/fft_rd hold.
- FLUSH: carries the final fft_load strobe. Then KICK.
- KICK: fft_start=1 for exactly this cycle. fft_adr=0. Then WAIT.
- WAIT: sets an armed flag once fft_done is sampled 0. Leaves for RDADR on the first fft_done=1 sampled while armed. A done left high from the previous frame is ignored.
- RDADR: fft_adr=bin (bin starts at 0). Then RDWAIT.
- RDWAIT: holds fft_adr for RD_LAT cycles, then captures fft_wd into the magnitude register and goes to OUT.
- OUT: m_valid=1. m_index=bin, m_last=(bin==N/2). On m_valid&m_ready: if m_last, clear bin and count and go to LOAD; else bin++ and go to RDADR.
- Magnitude: re=fft_wd[2w-1:w], im=fft_wd[w-1:0], both signed. a=|re| and b=|im| as w-bit unsigned (|-2^(w-1)| = 2^(w-1), no overflow). m_mag = max(a,b) + (min(a,b)>>1), w+1 bits, never saturates.
- busy=1 in all states except LOAD.
- Reset (any state, any cycle): state=LOAD, count=bin=armed=0. All outputs 0 except s_ready. The FFT core is reset in the same cycle by the shared reset.

## Timing
- Reset values: s_ready=0 while reset=0, and 1 from the first cycle after release. fft_load, fft_start, fft_adr, fft_rd, m_valid, m_index, m_mag, m_last, busy all 0.
- Load throughput: 1 sample/cycle. fft_load lags the accepting beat by 1 cycle.
- Last sample accepted in cycle t: fft_load high in t+1 (FLUSH), fft_start high in t+2 only. s_ready low from t+1.
- Readout: RDADR at cycle r with fft_adr=bin. fft_adr stable through r+RD_LAT. fft_wd sampled at the end of r+RD_LAT. m_valid rises in r+RD_LAT+1.
- m_valid, m_mag, m_index and m_last are stable while m_valid=1 and m_ready=0. m_valid falls the cycle after the handshake.
- Bin cadence without stall: RD_LAT+2 cycles per bin. N/2+1 bins per frame.
- After the m_last handshake, s_ready=1 in the next cycle.
- s_valid during non-LOAD states: ignored, no data lost on the block side (s_ready=0).

## Test plan
- Reset mid-readout: hold reset=0 for 3 cycles at bin 37. All outputs go 0. s_ready=1 the cycle after release. The next fft_load uses fft_adr=0.
- Continuous load of 512 samples 0..511 with s_valid=1: 512 fft_load strobes, fft_adr 0..511, fft_rd={n,16'h0000}. Single fft_start exactly 2 cycles after the last accept.
- Gapped s_valid (high every third cycle): fft_load only follows beats, addresses contiguous 0..511, no duplicate strobes.
- FFT model keeps fft_done=1 from the prior frame, drops it 2 cycles after start, raises it after 200 cycles. The first RDADR is 1 cycle after the rising done, never before.
- Magnitude vectors: fft_wd=32'h8000_0000 gives m_mag=17'h08000. fft_wd={16'h0003,16'hFFFC} gives m_mag=5. fft_wd=32'h8000_8000 gives m_mag=17'h0C000. With m_ready low for 10 cycles, m_valid and m_mag stay stable.
- Full frame, RD_LAT=2, m_ready=1: m_index runs 0..256, 4 cycles per bin, m_last only at 256. s_ready=1 the cycle after the final handshake, and the next frame loads at address 0.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
// Host-side driver for an N = 2^M point FFT core. Streams one frame of real
// samples into the core's load port, pulses start, waits for a fresh done,
// then reads bins 0..N/2 back and emits an approximate magnitude per bin on
// a valid/ready stream. Frames repeat back to back.
//
// Ports
//   clk_slow   : sole clock, rising edge
//   reset      : synchronous, active-low
//   s_valid/s_ready/s_data          : input sample stream (signed real)
//   fft_load/fft_adr/fft_rd         : core load port {real, imag}; fft_adr
//                                     also drives the readout address
//   fft_start  : one-cycle start pulse to the core
//   fft_done   : core completion level
//   fft_wd     : core result {real, imag}, valid RD_LAT cycles after fft_adr
//   m_valid/m_ready/m_index/m_mag/m_last : magnitude output stream
//   busy       : high whenever not accepting samples
module fft_frame_sequencer #(
    parameter int unsigned width  = 16,
    parameter int unsigned M      = 9,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clk_slow,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [width-1:0]     s_data,
    output logic                 fft_load,
    output logic [M-1:0]         fft_adr,
    output logic [2*width-1:0]   fft_rd,
    output logic                 fft_start,
    input  logic                 fft_done,
    input  logic [2*width-1:0]   fft_wd,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [M-1:0]         m_index,
    output logic [width:0]       m_mag,
    output logic                 m_last,
    output logic                 busy
);

    localparam int unsigned       N        = 1 << M;
    localparam int unsigned       LAT_W    = 2;
    localparam logic [M-1:0]      LAST_CNT = M'(N - 1);
    localparam logic [M-1:0]      LAST_BIN = M'(N / 2);
    localparam logic [LAT_W-1:0]  LAT_END  = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_FLUSH,
        ST_KICK,
        ST_WAIT,
        ST_RDADR,
        ST_RDWAIT,
        ST_OUT
    } state_t;

    state_t               state_q,     state_d;
    logic [M-1:0]         count_q,     count_d;
    logic [M-1:0]         bin_q,       bin_d;
    logic                 armed_q,     armed_d;
    logic [LAT_W-1:0]     lat_q,       lat_d;
    logic                 s_ready_q,   s_ready_d;
    logic                 fft_load_q,  fft_load_d;
    logic [M-1:0]         fft_adr_q,   fft_adr_d;
    logic [2*width-1:0]   fft_rd_q,    fft_rd_d;
    logic                 fft_start_q, fft_start_d;
    logic                 m_valid_q,   m_valid_d;
    logic [M-1:0]         m_index_q,   m_index_d;
    logic [width:0]       m_mag_q,     m_mag_d;
    logic                 m_last_q,    m_last_d;
    logic                 busy_q,      busy_d;

    // Approximate magnitude: max(|re|,|im|) + min(|re|,|im|)/2.
    // Two's-complement negate of the most negative value yields 2^(w-1),
    // which is exact when read as unsigned.
    logic [width-1:0] re_c, im_c, abs_re_c, abs_im_c, max_c, min_c;
    logic [width:0]   mag_c;

    always_comb begin
        re_c     = fft_wd[2*width-1:width];
        im_c     = fft_wd[width-1:0];
        abs_re_c = re_c[width-1] ? (~re_c + width'(1)) : re_c;
        abs_im_c = im_c[width-1] ? (~im_c + width'(1)) : im_c;
        if (abs_re_c >= abs_im_c) begin
            max_c = abs_re_c;
            min_c = abs_im_c;
        end else begin
            max_c = abs_im_c;
            min_c = abs_re_c;
        end
        mag_c = (width+1)'(max_c) + (width+1)'(min_c >> 1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        bin_d       = bin_q;
        armed_d     = armed_q;
        lat_d       = lat_q;
        fft_load_d  = 1'b0;
        fft_start_d = 1'b0;
        fft_adr_d   = fft_adr_q;
        fft_rd_d    = fft_rd_q;
        m_valid_d   = m_valid_q;
        m_index_d   = m_index_q;
        m_mag_d     = m_mag_q;
        m_last_d    = m_last_q;

        case (state_q)
            ST_LOAD: begin
                if (s_valid && s_ready_q) begin
                    fft_load_d = 1'b1;
                    fft_adr_d  = count_q;
                    fft_rd_d   = {s_data, width'(0)};
                    count_d    = count_q + M'(1);
                    if (count_q == LAST_CNT) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            // FLUSH is the cycle carrying the final load strobe; arm start.
            ST_FLUSH: begin
                fft_start_d = 1'b1;
                fft_adr_d   = '0;
                state_d     = ST_KICK;
            end
            ST_KICK: begin
                armed_d = 1'b0;
                state_d = ST_WAIT;
            end
            // Only a done that rises after having been seen low counts, so a
            // level left high by the previous frame is not mistaken for this one.
            ST_WAIT: begin
                if (!fft_done) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d   = 1'b0;
                    fft_adr_d = bin_q;
                    state_d   = ST_RDADR;
                end
            end
            ST_RDADR: begin
                lat_d   = '0;
                state_d = ST_RDWAIT;
            end
            ST_RDWAIT: begin
                if (lat_q == LAT_END) begin
                    m_valid_d = 1'b1;
                    m_mag_d   = mag_c;
                    m_index_d = bin_q;
                    m_last_d  = (bin_q == LAST_BIN);
                    state_d   = ST_OUT;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (m_last_q) begin
                        bin_d   = '0;
                        count_d = '0;
                        state_d = ST_LOAD;
                    end else begin
                        bin_d     = bin_q + M'(1);
                        fft_adr_d = bin_q + M'(1);
                        state_d   = ST_RDADR;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Decoded one cycle ahead so both are registered yet track the state.
        s_ready_d = (state_d == ST_LOAD);
        busy_d    = (state_d != ST_LOAD);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_slow) begin
        if (!reset) begin
            state_q     <= ST_LOAD;
            count_q     <= '0;
            bin_q       <= '0;
            armed_q     <= 1'b0;
            lat_q       <= '0;
            s_ready_q   <= 1'b0;
            fft_load_q  <= 1'b0;
            fft_adr_q   <= '0;
            fft_rd_q    <= '0;
            fft_start_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_index_q   <= '0;
            m_mag_q     <= '0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            bin_q       <= bin_d;
            armed_q     <= armed_d;
            lat_q       <= lat_d;
            s_ready_q   <= s_ready_d;
            fft_load_q  <= fft_load_d;
            fft_adr_q   <= fft_adr_d;
            fft_rd_q    <= fft_rd_d;
            fft_start_q <= fft_start_d;
            m_valid_q   <= m_valid_d;
            m_index_q   <= m_index_d;
            m_mag_q     <= m_mag_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign fft_load  = fft_load_q;
    assign fft_adr   = fft_adr_q;
    assign fft_rd    = fft_rd_q;
    assign fft_start = fft_start_q;
    assign m_valid   = m_valid_q;
    assign m_index   = m_index_q;
    assign m_mag     = m_mag_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: behavioural FFT-core model (result table
// with fixed read latency, done level with stale-high behaviour), load-beat
// scoreboard, magnitude reference model and a table of magnitude vectors.
module tb_fft_frame_sequencer;

    localparam int unsigned W    = 16;
    localparam int unsigned MB   = 9;
    localparam int unsigned RL   = 2;
    localparam int unsigned NPT  = 512;
    localparam int unsigned NBIN = NPT / 2 + 1;
    localparam int unsigned NVEC = 8;

    logic            clk_slow = 1'b0;
    logic            reset;
    logic            s_valid;
    logic            s_ready;
    logic [W-1:0]    s_data;
    logic            fft_load;
    logic [MB-1:0]   fft_adr;
    logic [2*W-1:0]  fft_rd;
    logic            fft_start;
    logic            fft_done;
    logic [2*W-1:0]  fft_wd;
    logic            m_valid;
    logic            m_ready;
    logic [MB-1:0]   m_index;
    logic [W:0]      m_mag;
    logic            m_last;
    logic            busy;

    always #5 clk_slow = ~clk_slow;

    fft_frame_sequencer #(.width(W), .M(MB), .RD_LAT(RL)) dut (
        .clk_slow  (clk_slow),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .fft_load  (fft_load),
        .fft_adr   (fft_adr),
        .fft_rd    (fft_rd),
        .fft_start (fft_start),
        .fft_done  (fft_done),
        .fft_wd    (fft_wd),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_index   (m_index),
        .m_mag     (m_mag),
        .m_last    (m_last),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_slow) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference magnitude from the defining formula on plain integers.
    function automatic logic [16:0] ref_mag(input logic [31:0] w);
        int re, im, a, b;
        re = int'($signed(w[31:16]));
        im = int'($signed(w[15:0]));
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        return (a > b) ? 17'(a + b / 2) : 17'(b + a / 2);
    endfunction

    // ---------------- FFT core model ----------------
    logic [31:0] res  [NPT];
    logic [31:0] pipe [RL];
    logic        done_r;
    logic        drun;
    int          dcnt;

    assign fft_wd   = pipe[RL-1];
    assign fft_done = done_r;

    always @(posedge clk_slow) begin
        if (!reset) begin
            done_r <= 1'b0;
            drun   <= 1'b0;
            dcnt   <= 0;
            for (int i = 0; i < int'(RL); i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= res[fft_adr];
            for (int i = 1; i < int'(RL); i++) pipe[i] <= pipe[i-1];
            if (fft_start) begin
                drun <= 1'b1;
                dcnt <= 0;
            end else if (drun) begin
                dcnt <= dcnt + 1;
                if (dcnt == 1)   done_r <= 1'b0;
                if (dcnt == 199) begin
                    done_r <= 1'b1;
                    drun   <= 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [15:0] d;
        int          c;
    } beat_t;

    beat_t       lq [$];
    int          last_acc_cyc = 0;
    logic        cad_en = 1'b0;

    int          ld_cnt = 0;
    int          starts_since = 0;
    int          exp_bin = 0;
    int          frames = 0;
    int          rise_cyc = 0;
    int          last_hs_cyc = 0;
    logic        first_pend = 1'b1;
    logic        prev_stall = 1'b0;
    logic        sready_chk = 1'b0;
    logic        mv_prev = 1'b0;
    logic        done_prev = 1'b0;
    logic [16:0] prev_mag = '0;
    logic [8:0]  prev_idx = '0;
    logic [16:0] got_mag [NBIN];

    always @(negedge clk_slow) begin
        if (!reset) begin
            prev_stall   = 1'b0;
            sready_chk   = 1'b0;
            mv_prev      = 1'b0;
            first_pend   = 1'b1;
            ld_cnt       = 0;
            starts_since = 0;
            exp_bin      = 0;
        end else begin
            if (sready_chk) begin
                chk("s_ready_after_last", s_ready, 1);
                sready_chk = 1'b0;
            end
            if (fft_done && !done_prev) rise_cyc = cyc;
            if (fft_load) begin
                chk("load_expected", lq.size() > 0, 1);
                if (lq.size() > 0) begin
                    beat_t b;
                    b = lq.pop_front();
                    chk("load_adr", fft_adr, ld_cnt);
                    chk("load_data", fft_rd, {b.d, 16'h0000});
                    chk("load_lag", cyc, b.c + 1);
                    ld_cnt++;
                end
            end
            if (fft_start) begin
                chk("start_cycle", cyc, last_acc_cyc + 2);
                chk("start_after_loads", ld_cnt, NPT);
                chk("single_start", starts_since, 0);
                starts_since++;
                ld_cnt = 0;
            end
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_mag", m_mag, prev_mag);
                chk("stall_idx", m_index, prev_idx);
            end
            if (m_valid && !mv_prev && first_pend) begin
                chk("first_valid_cycle", cyc, rise_cyc + RL + 2);
                first_pend = 1'b0;
            end
            if (m_valid && m_ready) begin
                chk("m_index", m_index, exp_bin);
                chk("m_mag", m_mag, ref_mag(res[exp_bin]));
                chk("m_last", m_last, exp_bin == NBIN - 1);
                chk("busy_readout", busy, 1);
                chk("s_ready_readout", s_ready, 0);
                if (cad_en && exp_bin != 0) chk("bin_cadence", cyc - last_hs_cyc, RL + 2);
                got_mag[exp_bin] = m_mag;
                last_hs_cyc = cyc;
                if (exp_bin == NBIN - 1) begin
                    exp_bin      = 0;
                    frames++;
                    sready_chk   = 1'b1;
                    first_pend   = 1'b1;
                    starts_since = 0;
                end else begin
                    exp_bin++;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_mag   = m_mag;
            prev_idx   = m_index;
            mv_prev    = m_valid;
        end
        done_prev = fft_done;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_slow);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_s_ready"},   s_ready,   0);
        chk({tag, "_fft_load"},  fft_load,  0);
        chk({tag, "_fft_start"}, fft_start, 0);
        chk({tag, "_fft_adr"},   fft_adr,   0);
        chk({tag, "_fft_rd"},    fft_rd,    0);
        chk({tag, "_m_valid"},   m_valid,   0);
        chk({tag, "_m_index"},   m_index,   0);
        chk({tag, "_m_mag"},     m_mag,     0);
        chk({tag, "_m_last"},    m_last,    0);
        chk({tag, "_busy"},      busy,      0);
    endtask

    // mode 0: back-to-back ramp 0..N-1; 1: beat every third cycle; 2: random
    task automatic load_frame(input int mode);
        int   n;
        int   k;
        logic v;
        n = 0;
        k = 0;
        while (n < int'(NPT) && k < 20000) begin
            if (s_ready) begin
                v = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
                s_valid = v;
                s_data  = (mode == 0) ? W'(n) : W'($urandom);
                if (v) begin
                    lq.push_back('{d: s_data, c: cyc});
                    last_acc_cyc = cyc;
                    n++;
                end
            end else begin
                s_valid = 1'($urandom_range(0, 1));
                s_data  = W'($urandom);
            end
            tick();
            k++;
        end
        s_valid = 1'b0;
        if (n < int'(NPT)) chk("load_timeout", n, NPT);
    endtask

    // rmode 0: m_ready held high; 1: random back-pressure
    task automatic readout(input int rmode);
        int k;
        int f0;
        k  = 0;
        f0 = frames;
        while (frames == f0 && k < 20000) begin
            s_valid = s_ready ? 1'b0 : 1'($urandom_range(0, 1));
            s_data  = W'($urandom);
            m_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("readout_done", frames, f0 + 1);
    endtask

    typedef struct {
        logic [31:0] wd;
        logic [16:0] mag;
    } vec_t;

    vec_t vec [NVEC];

    initial begin
        int k;
        vec[0] = '{wd: 32'h8000_0000, mag: 17'h08000};
        vec[1] = '{wd: 32'h0003_FFFC, mag: 17'd5};
        vec[2] = '{wd: 32'h8000_8000, mag: 17'h0C000};
        vec[3] = '{wd: 32'h0000_0000, mag: 17'h00000};
        vec[4] = '{wd: 32'h7FFF_7FFF, mag: 17'h0BFFE};
        vec[5] = '{wd: 32'hFFFF_0001, mag: 17'd1};
        vec[6] = '{wd: 32'h0005_FFF6, mag: 17'd12};
        vec[7] = '{wd: 32'h7FFF_8000, mag: 17'h0BFFF};

        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        for (int i = 0; i < int'(NPT); i++) res[i] = '0;

        // reset state
        repeat (3) tick();
        chk_idle("reset");
        reset = 1'b1;
        tick();
        chk("s_ready_after_release", s_ready, 1);
        chk("busy_after_release", busy, 0);

        // frame 1: ramp load, no back-pressure, table vectors in first bins
        for (int i = 0; i < int'(NPT); i++) res[i] = $urandom;
        for (int i = 0; i < int'(NVEC); i++) res[i] = vec[i].wd;
        cad_en = 1'b1;
        load_frame(0);
        readout(0);
        for (int i = 0; i < int'(NVEC); i++) chk($sformatf("vec%0d_mag", i), got_mag[i], vec[i].mag);
        cad_en = 1'b0;

        // frame 2: gapped load, stale done from frame 1, 10-cycle stall on bin 0
        for (int i = 0; i < int'(NPT); i++) res[i] = $urandom;
        res[0] = 32'h8000_0000;
        load_frame(1);
        m_ready = 1'b0;
        k = 0;
        while (!m_valid && k < 1000) begin
            tick();
            k++;
        end
        chk("stall_reached_valid", m_valid, 1);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_mag", m_mag, 17'h08000);
            chk("hold_index", m_index, 0);
            tick();
        end
        readout(1);

        // frame 3: random load, reset while presenting bin 37
        for (int i = 0; i < int'(NPT); i++) res[i] = $urandom;
        load_frame(2);
        k = 0;
        while (!(m_valid && m_index == 9'd37) && k < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("reached_bin37", m_index, 37);
        reset   = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("midreset");
        end
        reset = 1'b1;
        tick();
        chk("s_ready_after_midreset", s_ready, 1);

        // frame 4: random load and back-pressure after the reset
        for (int i = 0; i < int'(NPT); i++) res[i] = $urandom;
        load_frame(2);
        readout(1);

        chk("load_queue_drained", lq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule
